// File: rtl/timer_multi.sv
// N-channel countdown timer bank with tick-enable, one-shot/periodic modes,
// abort, expiry pulse, flicker window and a remaining-count readback mux.
module timer_multi #(
  parameter  int N_CH          = 4,
  parameter  int W             = 8,
  parameter  int FLICKER_TICKS = 5,
  localparam int SEL_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [N_CH-1:0]   start,
  input  logic [W-1:0]      length,
  input  logic [N_CH-1:0]   periodic,
  input  logic [N_CH-1:0]   freeze,
  input  logic [N_CH-1:0]   abort,
  output logic [N_CH-1:0]   flicker,
  output logic [N_CH-1:0]   done,
  output logic [N_CH-1:0]   expire,
  output logic              any_done,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [W-1:0]      rd_remaining
);

  // FROZEN is RUN with freeze high, so it never needs its own encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q     [N_CH];
  state_e          state_d     [N_CH];
  logic [W-1:0]    remaining_q [N_CH];
  logic [W-1:0]    remaining_d [N_CH];
  logic [W-1:0]    reload_q    [N_CH];
  logic [W-1:0]    reload_d    [N_CH];
  logic [N_CH-1:0] mode_q;
  logic [N_CH-1:0] mode_d;
  logic [N_CH-1:0] expire_q;
  logic [N_CH-1:0] expire_d;
  logic [N_CH-1:0] running;
  logic [N_CH-1:0] done_int;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= '0;
      expire_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        remaining_q[i] <= '0;
        reload_q[i]    <= '0;
      end
    end else begin
      mode_q   <= mode_d;
      expire_q <= expire_d;
      for (int i = 0; i < N_CH; i++) begin
        remaining_q[i] <= remaining_d[i];
        reload_q[i]    <= reload_d[i];
      end
    end
  end

  // Priority per channel: abort, then start (which swallows a same-cycle tick),
  // then an unfrozen tick while running; otherwise everything holds.
  always_comb begin
    mode_d   = mode_q;
    expire_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]     = state_q[i];
      remaining_d[i] = remaining_q[i];
      reload_d[i]    = reload_q[i];
      if (abort[i]) begin
        state_d[i]     = ST_IDLE;
        remaining_d[i] = '0;
      end else if (start[i]) begin
        reload_d[i]    = length;
        remaining_d[i] = length;
        mode_d[i]      = periodic[i];
        if (length == '0) begin
          state_d[i]  = ST_DONE;
          expire_d[i] = 1'b1;
        end else begin
          state_d[i]  = ST_RUN;
        end
      end else if (state_q[i] == ST_RUN && tick && !freeze[i]) begin
        if (remaining_q[i] > W'(1)) begin
          remaining_d[i] = remaining_q[i] - W'(1);
        end else begin
          expire_d[i] = 1'b1;
          if (mode_q[i]) begin
            remaining_d[i] = reload_q[i];
          end else begin
            remaining_d[i] = '0;
            state_d[i]     = ST_DONE;
          end
        end
      end
    end
  end

  always_comb begin
    running      = '0;
    done_int     = '0;
    flicker      = '0;
    rd_remaining = '0;
    for (int i = 0; i < N_CH; i++) begin
      running[i]  = (state_q[i] == ST_RUN);
      done_int[i] = (state_q[i] == ST_DONE);
      flicker[i]  = running[i] && (remaining_q[i] != '0) &&
                    (remaining_q[i] <= W'(FLICKER_TICKS));
      if (rd_sel == SEL_W'(i)) begin
        rd_remaining = remaining_q[i];
      end
    end
  end

  assign done     = done_int;
  assign expire   = expire_q;
  assign any_done = |done_int;

endmodule
